// File: rtl/pipelined_data_memory_if.sv
// Request/response bus of the pipelined data memory.
// Master drives requests and rsp_ready; slave returns req_ready and the response.
interface pipelined_data_memory_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/pipelined_data_memory.sv
// Byte-addressed little-endian data memory with in-order responses after LATENCY cycles.
// Optional MEM_STATS_EN builds load/store/error counters; otherwise stat_* are tied to 0.
module pipelined_data_memory #(
    parameter int SIZE            = 1024,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    pipelined_data_memory_if.slave  bus,
    output logic [31:0]             o_stat_rd,
    output logic [31:0]             o_stat_wr,
    output logic [31:0]             o_stat_err
);
    localparam int AW     = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int STAGES = LATENCY - 1;
    localparam int CW     = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic [7:0]    mem [SIZE];
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_fcnt;
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    rsp_t          r_fifo [MAX_OUTSTANDING];

    logic          w_acc, w_ret, w_err, w_push;
    logic [2:0]    w_nbytes;
    logic [32:0]   w_end;
    logic [AW-1:0] w_a0, w_a1, w_a2, w_a3;
    logic [7:0]    w_b0, w_b1, w_b2, w_b3;
    logic [31:0]   w_ld;
    rsp_t          w_rsp_in;
    logic          w_vld_pipe [0:STAGES];
    rsp_t          w_pipe     [0:STAGES];

    // req_ready depends only on registered occupancy, never on rsp_ready
    assign bus.req_ready = !i_rst && (r_cnt < CNT_MAX);
    assign w_acc = bus.req_valid && bus.req_ready;
    assign w_ret = bus.rsp_valid && bus.rsp_ready;

    always_comb begin
        w_nbytes = 3'd4;
        case (bus.req_size)
            2'b00:   w_nbytes = 3'd1;
            2'b01:   w_nbytes = 3'd2;
            default: w_nbytes = 3'd4;
        endcase
    end

    assign w_end = {1'b0, bus.req_addr} + {30'd0, w_nbytes};
    assign w_err = (bus.req_size == 2'b11)
                || (bus.req_size == 2'b01 && bus.req_addr[0])
                || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                || (w_end > 33'(SIZE));

    // Byte lanes are only meaningful when w_err is clear, so wrap-around is harmless
    assign w_a0 = bus.req_addr[AW-1:0];
    assign w_a1 = w_a0 + AW'(1);
    assign w_a2 = w_a0 + AW'(2);
    assign w_a3 = w_a0 + AW'(3);
    assign w_b0 = mem[w_a0];
    assign w_b1 = mem[w_a1];
    assign w_b2 = mem[w_a2];
    assign w_b3 = mem[w_a3];

    always_comb begin
        w_ld = '0;
        case (bus.req_size)
            2'b00:   w_ld = {{24{bus.req_signed & w_b0[7]}}, w_b0};
            2'b01:   w_ld = {{16{bus.req_signed & w_b1[7]}}, w_b1, w_b0};
            default: w_ld = {w_b3, w_b2, w_b1, w_b0};
        endcase
        w_rsp_in       = '0;
        w_rsp_in.err   = w_err;
        w_rsp_in.rdata = (w_err || bus.req_we) ? 32'd0 : w_ld;
    end

    always_ff @(posedge i_clk) begin
        if (w_acc && bus.req_we && !w_err) begin
            mem[w_a0] <= bus.req_wdata[7:0];
            if (bus.req_size != 2'b00)
                mem[w_a1] <= bus.req_wdata[15:8];
            if (bus.req_size == 2'b10) begin
                mem[w_a2] <= bus.req_wdata[23:16];
                mem[w_a3] <= bus.req_wdata[31:24];
            end
        end
    end

    assign w_vld_pipe[0] = w_acc;
    assign w_pipe[0]     = w_rsp_in;

    for (genvar g = 1; g <= STAGES; g++) begin : g_stg
        logic r_v;
        rsp_t r_d;
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_v <= 1'b0;
                r_d <= '0;
            end else begin
                r_v <= w_vld_pipe[g-1];
                r_d <= w_pipe[g-1];
            end
        end
        assign w_vld_pipe[g] = r_v;
        assign w_pipe[g]     = r_d;
    end

    assign w_push = w_vld_pipe[STAGES];

    // r_cnt covers pipeline plus FIFO, so the FIFO can never overflow
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_fcnt <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wp] <= w_pipe[STAGES];
                r_wp         <= (r_wp == PTR_LAST) ? '0 : r_wp + 1'b1;
            end
            if (w_ret)
                r_rp <= (r_rp == PTR_LAST) ? '0 : r_rp + 1'b1;
            case ({w_push, w_ret})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
            case ({w_acc, w_ret})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign bus.rsp_valid = (r_fcnt != '0);
    assign bus.rsp_rdata = bus.rsp_valid ? r_fifo[r_rp].rdata : 32'd0;
    assign bus.rsp_err   = bus.rsp_valid ? r_fifo[r_rp].err   : 1'b0;

`ifdef MEM_STATS_EN
    logic [31:0] r_stat_rd, r_stat_wr, r_stat_err;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stat_rd  <= '0;
            r_stat_wr  <= '0;
            r_stat_err <= '0;
        end else if (w_acc) begin
            if (bus.req_we) r_stat_wr <= r_stat_wr + 32'd1;
            else            r_stat_rd <= r_stat_rd + 32'd1;
            if (w_err)      r_stat_err <= r_stat_err + 32'd1;
        end
    end
    assign o_stat_rd  = r_stat_rd;
    assign o_stat_wr  = r_stat_wr;
    assign o_stat_err = r_stat_err;
`else
    assign o_stat_rd  = 32'd0;
    assign o_stat_wr  = 32'd0;
    assign o_stat_err = 32'd0;
`endif
endmodule

// File: tb/tb_pipelined_data_memory.sv
// Scoreboard bench for pipelined_data_memory: expected responses come from a byte-array
// model at issue time; a separate monitor retires and compares them in order.
module tb_pipelined_data_memory;
    localparam int SIZE = 1024;
    localparam int LAT  = 2;
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] stat_rd, stat_wr, stat_err;

    pipelined_data_memory_if bus();

    pipelined_data_memory #(.SIZE(SIZE), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus),
        .o_stat_rd(stat_rd), .o_stat_wr(stat_wr), .o_stat_err(stat_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] data;
        bit          lat_chk;
        int          acc_cyc;
    } exp_t;

    exp_t         sb[$];
    byte unsigned refmem [SIZE];
    int checks = 0, fails = 0, cyc = 0, stalls = 0;
    int m_rd = 0, m_wr = 0, m_err = 0;
    bit lat_mode = 0, bp_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (bp_mode) begin
        #1 bus.rsp_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain byte array, little-endian, errors decided from the access rules
    function automatic exp_t model(bit we, logic [1:0] sz, bit sg, logic [31:0] a, logic [31:0] wd);
        exp_t e;
        int nb;
        longint v;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.err = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
             || (longint'(a) + nb > SIZE);
        e.data = 0; e.lat_chk = 0; e.acc_cyc = 0;
        if (!e.err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) refmem[int'(a) + i] = 8'(wd >> (8 * i));
            end else begin
                v = 0;
                for (int i = 0; i < nb; i++) v += longint'(refmem[int'(a) + i]) << (8 * i);
                if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
                e.data = v[31:0];
            end
        end
        if (we) m_wr++; else m_rd++;
        if (e.err) m_err++;
        return e;
    endfunction

    task automatic issue(bit we, logic [1:0] sz, bit sg, logic [31:0] a, logic [31:0] wd);
        int n = 0;
        bit ok = 0;
        exp_t e;
        bus.req_valid = 1; bus.req_we = we; bus.req_size = sz;
        bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
        while (!ok) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1;
            else begin
                n++; stalls++;
                if (n > 100) begin chk("req_ready timeout", bus.req_ready, 1); break; end
            end
        end
        if (ok) begin
            e = model(we, sz, sg, a, wd);
            e.lat_chk = lat_mode;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.req_valid = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin @(posedge clk); n++; end
        chk("drain", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_stats(string tag);
`ifdef MEM_STATS_EN
        chk({tag, " stat_rd"}, stat_rd, m_rd);
        chk({tag, " stat_wr"}, stat_wr, m_wr);
        chk({tag, " stat_err"}, stat_err, m_err);
`else
        chk({tag, " stat_rd"}, stat_rd, 0);
        chk({tag, " stat_wr"}, stat_wr, 0);
        chk({tag, " stat_err"}, stat_err, 0);
`endif
    endtask

    // Monitor: retire/compare, head-stability while stalled, first-valid latency
    exp_t        mon_e;
    bit          seen = 0, held = 0;
    int          seen_cyc = 0;
    logic [32:0] held_v;
    always @(negedge clk) begin
        if (rst) begin
            seen = 0; held = 0;
        end else begin
            if (held && bus.rsp_valid) chk("rsp stable", {bus.rsp_err, bus.rsp_rdata}, held_v);
            if (bus.rsp_valid && !seen) begin seen = 1; seen_cyc = cyc; end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) chk("unexpected rsp_valid", bus.rsp_valid, 0);
                else begin
                    mon_e = sb.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, mon_e.data);
                    chk("rsp_err", bus.rsp_err, mon_e.err);
                    if (mon_e.lat_chk) chk("latency", seen_cyc - mon_e.acc_cyc, LAT);
                end
                seen = 0; held = 0;
            end else if (bus.rsp_valid) begin
                held = 1; held_v = {bus.rsp_err, bus.rsp_rdata};
            end else held = 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, n;
        logic [1:0] sz;
        logic [31:0] a;
        bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_signed = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.rsp_ready = 1;
        repeat (3) @(posedge clk); #1;
        chk("rst req_ready", bus.req_ready, 0);
        chk("rst rsp_valid", bus.rsp_valid, 0);
        chk("rst rsp_rdata", bus.rsp_rdata, 0);
        chk("rst rsp_err", bus.rsp_err, 0);
        chk_stats("rst");
        rst = 0;

        for (int i = 0; i < SIZE; i += 4) issue(1, 2'd2, 0, i, $urandom);
        wait_drain();

        // Word store then load with exact latency
        lat_mode = 1;
        issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
        issue(0, 2'd2, 0, 32'h10, 0);
        wait_drain();
        lat_mode = 0;

        // Byte sign/zero extension
        issue(1, 2'd0, 0, 32'h20, 32'h0);
        issue(1, 2'd0, 0, 32'h21, 32'h80);
        issue(0, 2'd0, 1, 32'h21, 0);
        issue(0, 2'd0, 0, 32'h21, 0);
        issue(0, 2'd1, 0, 32'h20, 0);
        issue(0, 2'd1, 1, 32'h20, 0);

        // Error cases and range boundaries
        issue(0, 2'd2, 0, 32'h12, 0);
        issue(0, 2'd1, 0, 32'h13, 0);
        issue(0, 2'd3, 0, 32'h10, 0);
        issue(0, 2'd2, 0, SIZE - 2, 0);
        issue(1, 2'd3, 0, 32'h10, 32'h11223344);
        issue(1, 2'd2, 0, SIZE, 32'h55667788);
        issue(1, 2'd1, 0, SIZE - 1, 32'h9999);
        issue(0, 2'd0, 1, SIZE - 1, 0);
        issue(0, 2'd2, 0, SIZE - 4, 0);
        issue(0, 2'd2, 0, 32'h10, 0);
        wait_drain();
        chk_stats("errors");

        // Fill to MAX_OUTSTANDING with rsp_ready low, then drain one per cycle
        bus.rsp_ready = 0;
        acc = 0;
        bus.req_valid = 1; bus.req_we = 0; bus.req_size = 2'd2; bus.req_signed = 0;
        bus.req_addr = 32'h100;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                sb.push_back(model(0, 2'd2, 0, bus.req_addr, 0));
                acc++;
            end
            @(posedge clk); #1;
            bus.req_addr = $urandom_range(0, SIZE / 4 - 1) * 4;
        end
        bus.req_valid = 0;
        chk("accepted when full", acc, MAXO);
        chk("req_ready when full", bus.req_ready, 0);
        bus.rsp_ready = 1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin @(posedge clk); n++; end
        chk("drain cycles", n, MAXO);
        #1;

        // Full-rate random traffic, no stalls expected
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = $urandom_range(0, SIZE - 1);
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        chk("full-rate stalls", stalls, 0);
        wait_drain();

        // Random traffic under random backpressure, including illegal requests
        bp_mode = 1;
        for (int i = 0; i < 120; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom_range(0, SIZE + 8);
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        bp_mode = 0;
        #1 bus.rsp_ready = 1;
        wait_drain();
        chk_stats("random");

        // Reset with three requests in flight
        bus.rsp_ready = 0;
        issue(1, 2'd2, 0, 32'h80, 32'h1234ABCD);
        issue(0, 2'd2, 0, 32'h80, 0);
        issue(0, 2'd2, 0, 32'h84, 0);
        rst = 1;
        bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2'd2; bus.req_addr = 32'h40;
        bus.req_wdata = 32'h5555AAAA;
        @(negedge clk);
        chk("req_ready in rst", bus.req_ready, 0);
        @(posedge clk); #1;
        chk("rsp_valid after rst", bus.rsp_valid, 0);
        sb.delete();
        m_rd = 0; m_wr = 0; m_err = 0;
        rst = 0;
        bus.req_valid = 0;
        chk_stats("after rst");
        bus.rsp_ready = 1;
        repeat (6) @(posedge clk); #1;
        chk("no stale rsp", bus.rsp_valid, 0);
        issue(0, 2'd2, 0, 32'h80, 0);
        issue(0, 2'd2, 0, 32'h40, 0);
        wait_drain();
        chk_stats("final");
        chk("scoreboard empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
